// File: rtl/pipeline_pkg.sv
// Shared pipeline types: word width, dmem word-index field, store-buffer entry.
package pipeline_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned WIDX_HI = 22;
    localparam int unsigned WIDX_LO = 2;
    localparam int unsigned WIDX_W  = WIDX_HI - WIDX_LO + 1;

    // One buffered store: full byte address plus the word to write
    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } sb_entry_t;

    // Word index as decoded by dmem (aliases above bit 22 collapse)
    function automatic logic [WIDX_W-1:0] word_idx(input logic [WORD_W-1:0] a);
        return a[WIDX_HI:WIDX_LO];
    endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding lookup: compares a load word index against every live
// entry and returns the youngest matching store.
module sb_fwd_match
    import pipeline_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 21
) (
    input  logic [DEPTH-1:0]                 valid,
    input  sb_entry_t [DEPTH-1:0]            entries,
    input  logic [$clog2(DEPTH)-1:0]         rd_ptr,
    input  logic [$clog2(DEPTH)-1:0]         wr_ptr,
    input  logic [AW-1:0]                    ld_idx,
    output logic                             hit,
    output logic [WORD_W-1:0]                hit_data
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] idx;
    logic          past_tail;

    // Walk oldest to youngest from the head; later matches override earlier ones,
    // so the surviving match is the youngest. Slots beyond the tail are ignored.
    always_comb begin
        hit       = 1'b0;
        hit_data  = '0;
        idx       = rd_ptr;
        past_tail = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if ((k != 0) && (idx == wr_ptr)) begin
                past_tail = 1'b1;
            end
            if (!past_tail && valid[idx] &&
                (entries[idx].addr[WIDX_LO +: AW] == ld_idx)) begin
                hit      = 1'b1;
                hit_data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Word-granular store buffer between MEM stage and single-port dmem: queues
// stores, drains one per free cycle, forwards buffered data to loads.
module store_buffer
    import pipeline_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 21
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         st_valid,
    input  logic [31:0]                  st_addr,
    input  logic [31:0]                  st_data,
    input  logic                         ld_valid,
    input  logic [31:0]                  ld_addr,
    output logic [31:0]                  ld_data,
    input  logic                         fence,
    output logic                         stall,
    output logic                         dm_we,
    output logic [31:0]                  dm_a,
    output logic [31:0]                  dm_wd,
    input  logic [31:0]                  dm_rd,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt;
    logic [DEPTH-1:0]      vld;
    sb_entry_t [DEPTH-1:0] entries;

    logic                  full;
    logic                  is_empty;
    logic                  push;
    logic                  pop;
    sb_entry_t             head;
    logic                  fwd_hit;
    logic [WORD_W-1:0]     fwd_data;

    // Occupancy flags and handshake: loads own the port, so drain only without a load
    always_comb begin
        full     = (cnt == CW'(DEPTH));
        is_empty = (cnt == '0);
        stall    = (st_valid & full) | (fence & ~is_empty);
        push     = st_valid & ~stall;
        pop      = ~is_empty & ~ld_valid;
        head     = entries[rd_ptr];
    end

    assign empty = is_empty;
    assign count = cnt;

    // Pointers, occupancy count and per-slot valid bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            vld    <= '0;
        end else begin
            if (push) begin
                wr_ptr      <= wr_ptr + PW'(1);
                vld[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + PW'(1);
                vld[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry payload storage; contents are meaningless unless the slot is valid
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= '{addr: st_addr, data: st_data};
        end
    end

    // Youngest-match forwarding over live entries (head still visible while draining)
    sb_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fwd (
        .valid    (vld),
        .entries  (entries),
        .rd_ptr   (rd_ptr),
        .wr_ptr   (wr_ptr),
        .ld_idx   (ld_addr[WIDX_LO +: AW]),
        .hit      (fwd_hit),
        .hit_data (fwd_data)
    );

    assign ld_data = fwd_hit ? fwd_data : dm_rd;

    // dmem port arbitration: load address, else drain head, else idle zeros
    always_comb begin
        dm_we = 1'b0;
        dm_a  = '0;
        dm_wd = '0;
        if (ld_valid) begin
            dm_a = ld_addr;
        end else if (!is_empty) begin
            dm_we = 1'b1;
            dm_a  = head.addr;
            dm_wd = head.data;
        end
    end

    // Stall blocks any store that would overflow the buffer
    a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && full));
    a_cnt_bound:    assert property (@(posedge clk) disable iff (reset) cnt <= CW'(DEPTH));

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer against a queue-based behavioural model.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        fence;
    logic        stall;
    logic        dm_we;
    logic [31:0] dm_a;
    logic [31:0] dm_wd;
    logic [31:0] dm_rd;
    logic        empty;
    logic [2:0]  count;

    store_buffer #(.DEPTH(DEPTH), .AW(21)) dut (
        .clk      (clk),
        .reset    (reset),
        .st_valid (st_valid),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .fence    (fence),
        .stall    (stall),
        .dm_we    (dm_we),
        .dm_a     (dm_a),
        .dm_wd    (dm_wd),
        .dm_rd    (dm_rd),
        .empty    (empty),
        .count    (count)
    );

    always #5 clk = ~clk;

    // Bench dmem: combinational read, write on rising edge; survives DUT reset
    logic        mem_clr;
    logic [31:0] dmem [1024];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= 32'h0;
        end else if (dm_we) begin
            dmem[dm_a[11:2]] <= dm_wd;
        end
    end
    assign dm_rd = dmem[dm_a[11:2]];

    // Reference model: pending stores in program order plus the memory image
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic [31:0] ref_mem [1024];
    int          nvec = 0;
    int          nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a[22:2] == a[22:2]) return q[i].d;
        end
        return ref_mem[a[11:2]];
    endfunction

    function automatic logic model_stall();
        return (st_valid && (q.size() == DEPTH)) || (fence && (q.size() != 0));
    endfunction

    // Apply inputs at negedge and check every output against the model
    task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic lv, input logic [31:0] la, input logic fv);
        logic        e_we;
        logic [31:0] e_a;
        logic [31:0] e_wd;
        @(negedge clk);
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        ld_valid = lv;
        ld_addr  = la;
        fence    = fv;
        #1;
        e_we = !lv && (q.size() != 0);
        e_a  = lv ? la : ((q.size() != 0) ? q[0].a : 32'h0);
        e_wd = e_we ? q[0].d : 32'h0;
        chk("stall", 32'(stall), 32'(model_stall()));
        chk("dm_we", 32'(dm_we), 32'(e_we));
        chk("dm_a",  dm_a, e_a);
        chk("dm_wd", dm_wd, e_wd);
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        if (lv) chk("ld_data", ld_data, model_load(la));
    endtask

    // Advance one clock edge and commit the model's drain and push
    task automatic tick();
        logic do_pop;
        logic do_push;
        do_pop  = !ld_valid && (q.size() != 0);
        do_push = st_valid && !model_stall();
        @(posedge clk);
        if (do_pop) begin
            ref_mem[q[0].a[11:2]] = q[0].d;
            void'(q.pop_front());
        end
        if (do_push) q.push_back('{a: st_addr, d: st_data});
    endtask

    task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                        input logic lv, input logic [31:0] la, input logic fv);
        drive(sv, sa, sd, lv, la, fv);
        tick();
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    // Asynchronous reset mid-cycle; buffered stores are discarded, memory kept
    task automatic do_reset();
        @(negedge clk);
        st_valid = 1'b0;
        ld_valid = 1'b0;
        fence    = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_dm_we", 32'(dm_we), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] la;
        reset    = 1'b1;
        mem_clr  = 1'b1;
        st_valid = 1'b0;
        st_addr  = 32'h0;
        st_data  = 32'h0;
        ld_valid = 1'b0;
        ld_addr  = 32'h0;
        fence    = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        repeat (2) @(negedge clk);
        chk("init_empty", 32'(empty), 32'h1);
        chk("init_count", 32'(count), 32'h0);
        chk("init_dm_a",  dm_a, 32'h0);
        chk("init_dm_wd", dm_wd, 32'h0);
        reset   = 1'b0;
        mem_clr = 1'b0;

        // Single store drains the cycle after acceptance
        step(1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t2_we", 32'(dm_we), 32'h1);
        chk("t2_a",  dm_a, 32'h100);
        chk("t2_wd", dm_wd, 32'hDEADBEEF);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t2_empty", 32'(empty), 32'h1);
        tick();

        // Seed the load-miss word so dm_rd carries a recognisable value
        step(1'b1, 32'h800, 32'h5A5A5A5A, 1'b0, 32'h0, 1'b0);
        idle();

        // Fill under held load: 5th store stalls; then drain in order
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 1'b1, 32'h800, 1'b0);
            chk("t3_ld_miss", ld_data, 32'h5A5A5A5A);
            if (i == 4) chk("t3_stall5", 32'(stall), 32'h1);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
            chk("t3_drain_a", dm_a, 32'h200 + 32'(4 * i));
            tick();
        end

        // Youngest same-word store wins forwarding
        step(1'b1, 32'h40, 32'h11, 1'b1, 32'h800, 1'b0);
        step(1'b1, 32'h40, 32'h22, 1'b1, 32'h800, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h42, 1'b0);
        chk("t4_youngest", ld_data, 32'h22);
        tick();

        // Aliased address forwards; neighbour word misses to dmem
        step(1'b1, 32'h40, 32'h33, 1'b1, 32'h800, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h00800040, 1'b0);
        chk("t5_alias", ld_data, 32'h33);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h44, 1'b0);
        chk("t5_miss", ld_data, 32'h0);
        tick();
        repeat (4) idle();

        // Reset with stores pending: they never reach dmem
        step(1'b1, 32'h300, 32'h0000BAD0, 1'b1, 32'h800, 1'b0);
        step(1'b1, 32'h304, 32'h0000BAD4, 1'b1, 32'h800, 1'b0);
        do_reset();
        repeat (3) idle();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h300, 1'b0);
        chk("t1_lost", ld_data, 32'h0);
        tick();

        // Fence with three entries: stall for three cycles, clear on the fourth
        for (int i = 0; i < 3; i++) step(1'b1, 32'h500 + 32'(4 * i), 32'hF0 + 32'(i), 1'b1, 32'h800, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
            chk("t6_fence", 32'(stall), (i < 3) ? 32'h1 : 32'h0);
            tick();
        end
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Randomised traffic over a small address set for hits, wraps and aliasing
        for (int n = 0; n < 600; n++) begin
            ra = {8'h0, 1'($urandom_range(0, 1)), 17'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            la = {8'h0, 1'($urandom_range(0, 1)), 17'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            step(1'($urandom_range(0, 9) < 6), ra, $urandom(),
                 1'($urandom_range(0, 9) < 4), la, 1'($urandom_range(0, 9) == 0));
        end
        repeat (DEPTH + 1) idle();
        for (int w = 0; w < 16; w++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 32'(w * 4), 1'b0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
